// File: rtl/saturn_phase_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : saturn_phase_gen_if
// Brief    : Control/status bundle between the Saturn core and its phase sequencer.
// Revision : 1.0
// ============================================================================
interface saturn_phase_gen_if #(
    parameter int PHASES = 4,
    parameter int CTR_W  = 32,
    parameter int PH_W   = $clog2(PHASES)
);
    logic              i_stall;
    logic              i_step_mode;
    logic              i_step;
    logic              i_limit_en;
    logic              i_max_load;
    logic [CTR_W-1:0]  i_max_cycle;
    logic [PH_W-1:0]   o_phase;
    logic [PHASES-1:0] o_ph_en;
    logic [CTR_W-1:0]  o_cycle_ctr;
    logic              o_running;
    logic              o_halt;

    modport master (
        output i_stall, i_step_mode, i_step, i_limit_en, i_max_load, i_max_cycle,
        input  o_phase, o_ph_en, o_cycle_ctr, o_running, o_halt
    );

    modport slave (
        input  i_stall, i_step_mode, i_step, i_limit_en, i_max_load, i_max_cycle,
        output o_phase, o_ph_en, o_cycle_ctr, o_running, o_halt
    );
endinterface
`default_nettype wire

// File: rtl/saturn_phase_gen.sv
`default_nettype none
// ============================================================================
// Module   : saturn_phase_gen
// Brief    : Saturn phase sequencer with stall/single-step gating and cycle limit.
// Revision : 1.0
// ============================================================================
module saturn_phase_gen #(
    parameter int PHASES        = 4,
    parameter int PH_W          = $clog2(PHASES),
    parameter int CTR_W         = 32,
    parameter int CTR_PHASE     = 0,
    parameter int MAX_CYCLE_RST = 35
) (
    input  wire logic          i_clk,
    input  wire logic          i_reset,
    saturn_phase_gen_if.slave  io_bus
);
    localparam logic [PH_W-1:0]   c_last_phase  = PH_W'(PHASES - 1);
    localparam logic [PH_W-1:0]   c_ctr_phase   = PH_W'(CTR_PHASE);
    localparam logic [PH_W:0]     c_credit_full = (PH_W + 1)'(PHASES);
    localparam logic [PH_W:0]     c_credit_one  = (PH_W + 1)'(1);
    localparam logic [CTR_W-1:0]  c_max_rst     = CTR_W'(MAX_CYCLE_RST);
    localparam logic [CTR_W-1:0]  c_ctr_one     = CTR_W'(1);
    localparam logic [PHASES-1:0] c_en_one      = PHASES'(1);
    localparam logic [PH_W-1:0]   c_phase_one   = PH_W'(1);

    logic [PH_W-1:0]   r_phase;
    logic [PHASES-1:0] r_ph_en;
    logic [CTR_W-1:0]  r_ctr;
    logic [CTR_W-1:0]  r_max;
    logic [PH_W:0]     r_credit;
    logic              r_halt;

    logic [CTR_W-1:0]  w_max_p1;
    logic              w_limit_hit;
    logic              w_adv;
    logic [PH_W-1:0]   w_phase_nxt;

    // The limit compares against the registered max, so a fresh load takes effect one cycle later.
    assign w_max_p1    = r_max + c_ctr_one;
    assign w_limit_hit = io_bus.i_limit_en && (r_ctr == w_max_p1);
    assign w_adv       = !r_halt && !w_limit_hit && !io_bus.i_stall &&
                         (!io_bus.i_step_mode || (r_credit != '0));
    assign w_phase_nxt = (r_phase == c_last_phase) ? '0 : (r_phase + c_phase_one);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_phase  <= c_last_phase;
            r_ph_en  <= '0;
            r_ctr    <= '1;
            r_max    <= c_max_rst;
            r_credit <= '0;
            r_halt   <= 1'b0;
        end else begin
            if (io_bus.i_max_load) begin
                r_max <= io_bus.i_max_cycle;
            end

            if (w_limit_hit) begin
                r_halt <= 1'b1;
            end

            // Enables mark the phase just completed and are never repeated for a held phase.
            if (w_adv) begin
                r_phase <= w_phase_nxt;
                r_ph_en <= c_en_one << r_phase;
                if (r_phase == c_ctr_phase) begin
                    r_ctr <= r_ctr + c_ctr_one;
                end
            end else begin
                r_ph_en <= '0;
            end

            // Step requests are accepted only once the previous round is fully spent.
            if (!io_bus.i_step_mode) begin
                r_credit <= '0;
            end else if (r_credit == '0) begin
                if (io_bus.i_step) begin
                    r_credit <= c_credit_full;
                end
            end else if (w_adv) begin
                r_credit <= r_credit - c_credit_one;
            end
        end
    end

    assign io_bus.o_phase     = r_phase;
    assign io_bus.o_ph_en     = r_ph_en;
    assign io_bus.o_cycle_ctr = r_ctr;
    assign io_bus.o_running   = w_adv;
    assign io_bus.o_halt      = r_halt;
endmodule
`default_nettype wire

// File: tb/tb_saturn_phase_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_saturn_phase_gen
// Brief    : Directed self-checking bench for saturn_phase_gen (three configurations).
// Revision : 1.0
// ============================================================================
module tb_saturn_phase_gen;
    logic clk  = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    logic rst2 = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    saturn_phase_gen_if #(.PHASES(4), .CTR_W(32)) b0 ();
    saturn_phase_gen_if #(.PHASES(4), .CTR_W(8))  b1 ();
    saturn_phase_gen_if #(.PHASES(6), .CTR_W(32)) b2 ();

    saturn_phase_gen #(.PHASES(4), .CTR_W(32), .CTR_PHASE(0), .MAX_CYCLE_RST(35))
        u0 (.i_clk(clk), .i_reset(rst0), .io_bus(b0));
    saturn_phase_gen #(.PHASES(4), .CTR_W(8), .CTR_PHASE(0), .MAX_CYCLE_RST(35))
        u1 (.i_clk(clk), .i_reset(rst1), .io_bus(b1));
    saturn_phase_gen #(.PHASES(6), .CTR_W(32), .CTR_PHASE(5), .MAX_CYCLE_RST(35))
        u2 (.i_clk(clk), .i_reset(rst2), .io_bus(b2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  ph4  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [3:0]  en4  [6] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [31:0] ctr4 [6] = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
        logic [2:0]  ph6  [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        logic [5:0]  en6  [7] = '{6'h20, 6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20};
        logic [31:0] ctr6 [7] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
        int hit_edge;
        int bad;
        int pulses;

        b0.i_stall = 0; b0.i_step_mode = 0; b0.i_step = 0; b0.i_limit_en = 0;
        b0.i_max_load = 0; b0.i_max_cycle = '0;
        b1.i_stall = 0; b1.i_step_mode = 0; b1.i_step = 0; b1.i_limit_en = 0;
        b1.i_max_load = 0; b1.i_max_cycle = '0;
        b2.i_stall = 0; b2.i_step_mode = 0; b2.i_step = 0; b2.i_limit_en = 0;
        b2.i_max_load = 0; b2.i_max_cycle = '0;
        repeat (2) tick();

        // ---- default configuration: reset values and free run
        chk("d0_rst_phase", b0.o_phase, 3);
        chk("d0_rst_phen", b0.o_ph_en, 0);
        chk("d0_rst_ctr", b0.o_cycle_ctr, 32'hFFFF_FFFF);
        chk("d0_rst_halt", b0.o_halt, 0);
        rst0 = 0;
        for (int e = 0; e < 6; e++) begin
            tick();
            chk($sformatf("d0_run_phase_e%0d", e + 1), b0.o_phase, ph4[e]);
            chk($sformatf("d0_run_phen_e%0d", e + 1), b0.o_ph_en, en4[e]);
            chk($sformatf("d0_run_ctr_e%0d", e + 1), b0.o_cycle_ctr, ctr4[e]);
        end
        tick();
        chk("d0_pre_stall_phase", b0.o_phase, 2);
        chk("d0_pre_stall_phen", b0.o_ph_en, 4'b0010);

        // ---- stall for three cycles at phase 2
        b0.i_stall = 1;
        #1 chk("d0_stall_running", b0.o_running, 0);
        for (int s = 0; s < 3; s++) begin
            tick();
            chk($sformatf("d0_stall_phase_%0d", s), b0.o_phase, 2);
            chk($sformatf("d0_stall_phen_%0d", s), b0.o_ph_en, 0);
            chk($sformatf("d0_stall_ctr_%0d", s), b0.o_cycle_ctr, 1);
        end
        b0.i_stall = 0;
        #1 chk("d0_unstall_running", b0.o_running, 1);
        tick();
        chk("d0_unstall_phen", b0.o_ph_en, 4'b0100);
        chk("d0_unstall_phase", b0.o_phase, 3);

        // ---- single step: one round, second step ignored, stall stretches the round
        b0.i_step_mode = 1;
        #1 chk("d0_step_idle_running", b0.o_running, 0);
        tick();
        chk("d0_step_idle_phen", b0.o_ph_en, 0);
        b0.i_step = 1;
        tick();
        b0.i_step = 0;
        chk("d0_step_grant_phase", b0.o_phase, 3);
        chk("d0_step_grant_phen", b0.o_ph_en, 0);
        tick();
        chk("d0_step_p1", b0.o_ph_en, 4'b1000);
        b0.i_step = 1;
        tick();
        b0.i_step = 0;
        chk("d0_step_p2", b0.o_ph_en, 4'b0001);
        chk("d0_step_ctr", b0.o_cycle_ctr, 2);
        b0.i_stall = 1;
        tick();
        b0.i_stall = 0;
        chk("d0_step_stall_phen", b0.o_ph_en, 0);
        chk("d0_step_stall_phase", b0.o_phase, 1);
        tick();
        chk("d0_step_p3", b0.o_ph_en, 4'b0010);
        tick();
        chk("d0_step_p4", b0.o_ph_en, 4'b0100);
        pulses = 0;
        repeat (6) begin
            tick();
            if (b0.o_ph_en != 0 || b0.o_phase != 3) pulses++;
        end
        chk("d0_step_hold_extra", pulses, 0);
        b0.i_step_mode = 0;
        tick();
        chk("d0_freerun_phase", b0.o_phase, 0);
        chk("d0_freerun_phen", b0.o_ph_en, 4'b1000);

        // ---- mid-operation reset, then cycle limit at default max 35
        rst0 = 1;
        tick();
        chk("d0_rerst_phase", b0.o_phase, 3);
        chk("d0_rerst_phen", b0.o_ph_en, 0);
        chk("d0_rerst_ctr", b0.o_cycle_ctr, 32'hFFFF_FFFF);
        b0.i_limit_en = 1;
        rst0 = 0;
        hit_edge = 0;
        for (int e = 1; e <= 200 && hit_edge == 0; e++) begin
            tick();
            if (b0.o_cycle_ctr == 36) hit_edge = e;
        end
        chk("d0_lim_edge", hit_edge, 146);
        chk("d0_lim_phase", b0.o_phase, 1);
        chk("d0_lim_phen", b0.o_ph_en, 4'b0001);
        chk("d0_lim_halt_pre", b0.o_halt, 0);
        chk("d0_lim_running", b0.o_running, 0);
        tick();
        chk("d0_halt_set", b0.o_halt, 1);
        chk("d0_halt_phen", b0.o_ph_en, 0);
        chk("d0_halt_phase", b0.o_phase, 1);
        chk("d0_halt_ctr", b0.o_cycle_ctr, 36);
        bad = 0;
        repeat (100) begin
            tick();
            if (b0.o_phase != 1 || b0.o_ph_en != 0 || b0.o_cycle_ctr != 36 || b0.o_halt != 1) bad++;
        end
        chk("d0_halt_frozen", bad, 0);
        b0.i_max_load = 1;
        b0.i_max_cycle = 32'd1000;
        b0.i_limit_en = 0;
        tick();
        b0.i_max_load = 0;
        tick();
        chk("d0_halt_sticky", b0.o_halt, 1);
        chk("d0_halt_sticky_phase", b0.o_phase, 1);

        // ---- 8-bit counter: max = FF compares against 0, wraps then halts
        b1.i_max_load = 1;
        b1.i_max_cycle = 8'hFF;
        rst1 = 0;
        tick();
        b1.i_max_load = 0;
        b1.i_limit_en = 1;
        chk("d1_wrap_ctr_e1", b1.o_cycle_ctr, 8'hFF);
        #1 chk("d1_wrap_running_e1", b1.o_running, 1);
        tick();
        chk("d1_wrap_ctr_e2", b1.o_cycle_ctr, 0);
        chk("d1_wrap_phase_e2", b1.o_phase, 1);
        chk("d1_wrap_running_e2", b1.o_running, 0);
        tick();
        chk("d1_wrap_halt", b1.o_halt, 1);
        chk("d1_wrap_phen", b1.o_ph_en, 0);
        chk("d1_wrap_ctr_hold", b1.o_cycle_ctr, 0);

        // ---- 8-bit counter: load max = 3 at ctr = 1, halt at ctr = 4
        rst1 = 1;
        tick();
        chk("d1_rerst_halt", b1.o_halt, 0);
        chk("d1_rerst_ctr", b1.o_cycle_ctr, 8'hFF);
        rst1 = 0;
        repeat (6) tick();
        chk("d1_load_ctr", b1.o_cycle_ctr, 1);
        b1.i_max_load = 1;
        b1.i_max_cycle = 8'd3;
        tick();
        b1.i_max_load = 0;
        hit_edge = 0;
        for (int e = 8; e <= 60 && hit_edge == 0; e++) begin
            tick();
            if (b1.o_halt == 1'b1) hit_edge = e;
        end
        chk("d1_load_halt_edge", hit_edge, 19);
        chk("d1_load_halt_ctr", b1.o_cycle_ctr, 4);

        // ---- six phases, counter ticks when leaving phase 5
        chk("d2_rst_phase", b2.o_phase, 5);
        chk("d2_rst_phen", b2.o_ph_en, 0);
        chk("d2_rst_ctr", b2.o_cycle_ctr, 32'hFFFF_FFFF);
        rst2 = 0;
        for (int e = 0; e < 7; e++) begin
            tick();
            chk($sformatf("d2_run_phase_e%0d", e + 1), b2.o_phase, ph6[e]);
            chk($sformatf("d2_run_phen_e%0d", e + 1), b2.o_ph_en, en6[e]);
            chk($sformatf("d2_run_ctr_e%0d", e + 1), b2.o_cycle_ctr, ctr6[e]);
        end
        b2.i_step_mode = 1;
        b2.i_step = 1;
        tick();
        b2.i_step = 0;
        pulses = 0;
        repeat (12) begin
            tick();
            if (b2.o_ph_en != 0) pulses++;
        end
        chk("d2_step_pulses", pulses, 6);
        chk("d2_step_phase", b2.o_phase, 0);
        chk("d2_step_ctr", b2.o_cycle_ctr, 2);

        // ---- reset mid-step clears credit
        b2.i_step = 1;
        tick();
        b2.i_step = 0;
        repeat (2) tick();
        chk("d2_midstep_phase", b2.o_phase, 2);
        rst2 = 1;
        tick();
        chk("d2_rerst_phase", b2.o_phase, 5);
        chk("d2_rerst_phen", b2.o_ph_en, 0);
        chk("d2_rerst_ctr", b2.o_cycle_ctr, 32'hFFFF_FFFF);
        rst2 = 0;
        #1 chk("d2_rerst_running", b2.o_running, 0);
        tick();
        chk("d2_rerst_hold_phase", b2.o_phase, 5);
        chk("d2_rerst_hold_phen", b2.o_ph_en, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
